// File: rtl/io_frame_pkg.sv
// io_frame_pkg: shared types and constants for the pad/core frame bridge.
//   state_e      - bridge FSM states (IDLE=0, RECV=1, WAIT=2, OUT=3)
//   ERR_W        - width of the sticky error flag vector
//   ERR_OVERLEN  - bit index: beat arrived after the frame was already full
//   ERR_PROTO    - bit index: pad beat or core result arrived in the wrong phase
//   ERR_TIMEOUT  - bit index: core never answered within the timeout window
package io_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam int ERR_W       = 3;
  localparam int ERR_OVERLEN = 0;
  localparam int ERR_PROTO   = 1;
  localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/io_retime_reg.sv
// io_retime_reg: W-bit retiming register with a valid-gated load.
//   clk        in   1   rising-edge clock
//   clr_n_i    in   1   synchronous clear, active low (clears data and valid)
//   load_i     in   1   capture d_i this cycle; also becomes valid_o next cycle
//   d_i        in   W   data to capture
//   q_o        out  W   registered data
//   valid_o    out  1   registered copy of load_i
// ZERO_IDLE=0: q_o holds its value on cycles without a load.
// ZERO_IDLE=1: q_o returns to 0 on cycles without a load, so the data bus
//              is only non-zero while valid_o is high.
module io_retime_reg #(
  parameter int W         = 8,
  parameter bit ZERO_IDLE = 1'b0
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= d_i;
      end else if (ZERO_IDLE) begin
        data_q <= '0;
      end
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/io_frame_bridge.sv
// io_frame_bridge: retiming and protocol bridge between chip pads and the core.
// Registers pad inputs toward the core and core results toward the pads, frames
// pad_in_valid bursts and supervises the core's response.
//   clk, rst_n       clock and synchronous active-low reset
//   pad_in_valid/data    raw pad input beat
//   core_in_valid/data   registered beat to core (1 cycle latency, data holds)
//   core_out_valid/data  raw core result beat
//   pad_out_valid/data   registered result to pads (1 cycle, data 0 when idle)
//   busy                 FSM is not in IDLE
//   err_flags            sticky [0] overlen, [1] proto, [2] timeout
//   err_clr              clears err_flags; a simultaneous new error wins
// Handshake: both directions are valid-only streams with no back-pressure.
// A beat is transferred on any rising edge where its valid is high and the
// FSM is in the phase that accepts it; out-of-phase beats are discarded and
// reported through err_flags instead of stalling anyone.
module io_frame_bridge
  import io_frame_pkg::*;
#(
  parameter int IN_W      = 17,
  parameter int OUT_W     = 16,
  parameter int FRAME_LEN = 8,
  parameter int TIMEOUT   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_in_valid,
  input  logic [IN_W-1:0]  pad_in_data,
  output logic             core_in_valid,
  output logic [IN_W-1:0]  core_in_data,
  input  logic             core_out_valid,
  input  logic [OUT_W-1:0] core_out_data,
  output logic             pad_out_valid,
  output logic [OUT_W-1:0] pad_out_data,
  output logic             busy,
  output logic [ERR_W-1:0] err_flags,
  input  logic             err_clr
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BEAT_MAX = BW'(FRAME_LEN);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    to_q, to_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic             fwd_in, fwd_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      to_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Decisions use the current state only, so a beat arriving on the cycle the
  // FSM drops back to IDLE is still judged in WAIT/OUT and flagged as proto.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    to_d    = to_q;
    fwd_in  = 1'b0;
    fwd_out = 1'b0;
    err_set = '0;
    case (state_q)
      ST_IDLE: begin
        if (pad_in_valid) begin
          state_d = ST_RECV;
          beat_d  = BW'(1);
          fwd_in  = 1'b1;
        end
        if (core_out_valid) err_set[ERR_PROTO] = 1'b1;
      end
      ST_RECV: begin
        if (pad_in_valid) begin
          if (beat_q == BEAT_MAX) begin
            // Frame already full: drop the beat, counter stays saturated.
            err_set[ERR_OVERLEN] = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
            fwd_in = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
          to_d    = '0;
        end
        if (core_out_valid) err_set[ERR_PROTO] = 1'b1;
      end
      ST_WAIT: begin
        if (pad_in_valid) err_set[ERR_PROTO] = 1'b1;
        // A result arriving on the expiry cycle still counts as on time.
        if (core_out_valid) begin
          state_d = ST_OUT;
          fwd_out = 1'b1;
        end else if (to_q == TO_MAX) begin
          state_d              = ST_IDLE;
          err_set[ERR_TIMEOUT] = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_OUT: begin
        if (pad_in_valid) err_set[ERR_PROTO] = 1'b1;
        if (core_out_valid) fwd_out = 1'b1;
        else                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set | (err_clr ? '0 : err_q);
  end

  io_retime_reg #(.W(IN_W), .ZERO_IDLE(1'b0)) u_in_reg (
    .clk     (clk),
    .clr_n_i (rst_n),
    .load_i  (fwd_in),
    .d_i     (pad_in_data),
    .q_o     (core_in_data),
    .valid_o (core_in_valid)
  );

  io_retime_reg #(.W(OUT_W), .ZERO_IDLE(1'b1)) u_out_reg (
    .clk     (clk),
    .clr_n_i (rst_n),
    .load_i  (fwd_out),
    .d_i     (core_out_data),
    .q_o     (pad_out_data),
    .valid_o (pad_out_valid)
  );

  assign busy      = (state_q != ST_IDLE);
  assign err_flags = err_q;

endmodule

// File: tb/tb_io_frame_bridge.sv
module tb_io_frame_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pad_in_valid;
  logic [16:0] pad_in_data;
  logic        core_in_valid;
  logic [16:0] core_in_data;
  logic        core_out_valid;
  logic [15:0] core_out_data;
  logic        pad_out_valid;
  logic [15:0] pad_out_data;
  logic        busy;
  logic [2:0]  err_flags;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_frame_bridge #(.IN_W(17), .OUT_W(16), .FRAME_LEN(8), .TIMEOUT(100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_in_valid   (pad_in_valid),
    .pad_in_data    (pad_in_data),
    .core_in_valid  (core_in_valid),
    .core_in_data   (core_in_data),
    .core_out_valid (core_out_valid),
    .core_out_data  (core_out_data),
    .pad_out_valid  (pad_out_valid),
    .pad_out_data   (pad_out_data),
    .busy           (busy),
    .err_flags      (err_flags),
    .err_clr        (err_clr)
  );

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pad_in_valid   = 1'b0;
    pad_in_data    = '0;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    err_clr        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({core_in_valid, core_in_data, pad_out_valid, pad_out_data, busy, err_flags} !== '0) begin
      errors++;
      $display("FAIL reset_outputs civ=%0b cid=%h pov=%0b pod=%h busy=%0b err=%b expected all 0",
               core_in_valid, core_in_data, pad_out_valid, pad_out_data, busy, err_flags);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      pad_in_valid = 1'b1;
      pad_in_data  = 17'(i);
      tick();
      checks++;
      if (core_in_valid !== 1'b1 || core_in_data !== 17'(i)) begin
        errors++;
        $display("FAIL basic_beat%0d got v=%0b d=%h expected v=1 d=%h", i, core_in_valid, core_in_data, 17'(i));
      end
    end
    pad_in_valid = 1'b0;
    tick();
    checks++;
    if (core_in_valid !== 1'b0 || core_in_data !== 17'h00008 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_end_of_frame got v=%0b d=%h busy=%0b expected v=0 d=00008 busy=1",
               core_in_valid, core_in_data, busy);
    end
    for (int i = 0; i < 4; i++) tick();
    core_out_valid = 1'b1;
    core_out_data  = 16'h1234;
    tick();
    checks++;
    if (pad_out_valid !== 1'b1 || pad_out_data !== 16'h1234 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_pad_out got v=%0b d=%h busy=%0b expected v=1 d=1234 busy=1",
               pad_out_valid, pad_out_data, busy);
    end
    core_out_valid = 1'b0;
    core_out_data  = 16'h0;
    tick();
    checks++;
    if (pad_out_valid !== 1'b0 || pad_out_data !== 16'h0 || busy !== 1'b0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL basic_done got pov=%0b pod=%h busy=%0b err=%b expected 0 0000 0 000",
               pad_out_valid, pad_out_data, busy, err_flags);
    end
  endtask

  task automatic test_overlen();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      pad_in_valid = 1'b1;
      pad_in_data  = 17'(i);
      tick();
      if (i > 8) begin
        checks++;
        if (core_in_valid !== 1'b0 || core_in_data !== 17'h00008) begin
          errors++;
          $display("FAIL overlen_beat%0d got v=%0b d=%h expected v=0 d=00008", i, core_in_valid, core_in_data);
        end
      end
    end
    checks++;
    if (err_flags !== 3'b001) begin
      errors++;
      $display("FAIL overlen_flags got %b expected 001", err_flags);
    end
    pad_in_valid   = 1'b0;
    tick();
    core_out_valid = 1'b1;
    core_out_data  = 16'h00AA;
    tick();
    core_out_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    pad_in_valid = 1'b1;
    pad_in_data  = 17'h00011;
    tick();
    tick();
    pad_in_valid = 1'b0;
    tick();
    // The edge above was the first to see pad_in_valid low.
    for (int c = 1; c <= 99; c++) tick();
    checks++;
    if (busy !== 1'b1 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL timeout_99 got busy=%0b err=%b expected busy=1 err=000", busy, err_flags);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err_flags !== 3'b100) begin
      errors++;
      $display("FAIL timeout_100 got busy=%0b err=%b expected busy=0 err=100", busy, err_flags);
    end
  endtask

  task automatic test_proto();
    do_reset();
    core_out_valid = 1'b1;
    core_out_data  = 16'hDEAD;
    tick();
    checks++;
    if (pad_out_valid !== 1'b0 || pad_out_data !== 16'h0 || err_flags !== 3'b010) begin
      errors++;
      $display("FAIL proto_idle_out got v=%0b d=%h err=%b expected v=0 d=0000 err=010",
               pad_out_valid, pad_out_data, err_flags);
    end
    core_out_valid = 1'b0;
    pad_in_valid   = 1'b1;
    pad_in_data    = 17'h00055;
    tick();
    pad_in_valid   = 1'b0;
    tick();
    core_out_valid = 1'b1;
    core_out_data  = 16'hBEEF;
    tick();
    core_out_data  = 16'h0042;
    pad_in_valid   = 1'b1;
    pad_in_data    = 17'h1FFFF;
    tick();
    checks++;
    if (core_in_valid !== 1'b0 || core_in_data !== 17'h00055 || pad_out_valid !== 1'b1 ||
        pad_out_data !== 16'h0042 || busy !== 1'b1) begin
      errors++;
      $display("FAIL proto_out_pad got civ=%0b cid=%h pov=%0b pod=%h busy=%0b expected 0 00055 1 0042 1",
               core_in_valid, core_in_data, pad_out_valid, pad_out_data, busy);
    end
    idle_inputs();
    tick();
    checks++;
    if (pad_out_valid !== 1'b0 || pad_out_data !== 16'h0 || busy !== 1'b0 || err_flags !== 3'b010) begin
      errors++;
      $display("FAIL proto_final got pov=%0b pod=%h busy=%0b err=%b expected 0 0000 0 010",
               pad_out_valid, pad_out_data, busy, err_flags);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      pad_in_valid = 1'b1;
      pad_in_data  = 17'(16'h100 + i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({core_in_valid, core_in_data, pad_out_valid, pad_out_data, busy, err_flags} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs civ=%0b cid=%h pov=%0b pod=%h busy=%0b err=%b expected all 0",
               core_in_valid, core_in_data, pad_out_valid, pad_out_data, busy, err_flags);
    end
    rst_n        = 1'b1;
    pad_in_valid = 1'b0;
    tick();
    pad_in_valid = 1'b1;
    pad_in_data  = 17'h0ABCD;
    tick();
    checks++;
    if (core_in_valid !== 1'b1 || core_in_data !== 17'h0ABCD || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_new_frame got v=%0b d=%h busy=%0b expected v=1 d=0abcd busy=1",
               core_in_valid, core_in_data, busy);
    end
    pad_in_valid   = 1'b0;
    tick();
    core_out_valid = 1'b1;
    core_out_data  = 16'h5A5A;
    tick();
    core_out_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL midreset_clean got busy=%0b err=%b expected busy=0 err=000", busy, err_flags);
    end
  endtask

  task automatic test_err_clr();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      pad_in_valid = 1'b1;
      pad_in_data  = 17'(i);
      tick();
    end
    err_clr     = 1'b1;
    pad_in_data = 17'h0000A;
    tick();
    checks++;
    if (err_flags !== 3'b001) begin
      errors++;
      $display("FAIL errclr_set_wins got %b expected 001", err_flags);
    end
    pad_in_valid = 1'b0;
    tick();
    checks++;
    if (err_flags !== 3'b000) begin
      errors++;
      $display("FAIL errclr_alone got %b expected 000", err_flags);
    end
    err_clr        = 1'b0;
    core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL errclr_done got busy=%0b err=%b expected busy=0 err=000", busy, err_flags);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_overlen();
    test_timeout();
    test_proto();
    test_mid_reset();
    test_err_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
